load_store_unit: RTL and testbench

Parametrised load/store unit for the execute stage: computes the effective byte address as base plus offset and performs byte, halfword or word accesses on an internal synchronous data memory. It supports sign/zero extension, misalignment and range checking, and valid/ready request and response handshakes. The block replaces the single-width, always-word, handshake-less load/store path in front of data memory.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response bundle between the execute stage and the load/store unit.
// master = requester, slave = load_store_unit.
interface load_store_unit_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_base;
  logic [31:0]       req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_base,
    output req_offset, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_base,
    input  req_offset, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load/store unit with an internal synchronous data memory.
// Three-state flow: IDLE accepts, ACCESS drives memory, RESP holds the reply.
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, RESP
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        err_q, err_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  logic [31:0] ea;
  logic        mis;
  logic        oor;
  logic [1:0]  err_new;

  assign ea  = bus.req_base + bus.req_offset;
  assign oor = |ea[31:ADDR_W+2];

  always_comb begin
    mis = 1'b1;
    unique case (bus.req_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = ea[0];
      2'b10:   mis = |ea[1:0];
      default: mis = 1'b1;
    endcase
  end

  // misaligned outranks out-of-range
  assign err_new = mis ? 2'b01 :
                   oor ? 2'b10 : 2'b00;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    err_d   = err_q;
    uns_d   = uns_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = ea[ADDR_W+1:0];
          size_d  = bus.req_size;
          err_d   = err_new;
          uns_d   = bus.req_unsigned;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      err_q   <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      err_q   <= err_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  logic [3:0]        be;
  logic [DATA_W-1:0] wd;
  logic              mem_en;
  logic [ADDR_W-1:0] idx;

  assign idx    = addr_q[ADDR_W+1:2];
  assign mem_en = (state_q == ACCESS) &&
                  (err_q == 2'b00);

  always_comb begin
    be = 4'b0000;
    wd = '0;
    unique case (1'b1)
      size_q == 2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      size_q == 2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
  end

  // memory array and its read register carry no reset
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (we_q) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[idx][8*i +: 8] <= wd[8*i +: 8];
          end
        end
      end else begin
        rd_q <= mem[idx];
      end
    end
  end

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ld;

  assign sh = rd_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld = rd_q;
    unique case (size_q)
      2'b00: ld = uns_q ?
        {{(DATA_W-8){1'b0}}, sh[7:0]} :
        {{(DATA_W-8){sh[7]}}, sh[7:0]};
      2'b01: ld = uns_q ?
        {{(DATA_W-16){1'b0}}, sh[15:0]} :
        {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default: ld = rd_q;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = bus.resp_valid ?
                          err_q : 2'b00;
  assign bus.resp_rdata =
    (bus.resp_valid && !we_q &&
     err_q == 2'b00) ? ld : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected replies,
// a negedge monitor pops and compares on each response handshake.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_W(32)) bus ();

  load_store_unit #(
    .DATA_W(32),
    .ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [33:0] sb[$];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h",
               name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid &&
        bus.resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp rdata=%h err=%b",
                 bus.resp_rdata, bus.resp_err);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        if ({bus.resp_err, bus.resp_rdata} !== e) begin
          errors++;
          $display("FAIL resp got rdata=%h err=%b want rdata=%h err=%b",
                   bus.resp_rdata, bus.resp_err,
                   e[31:0], e[33:32]);
        end
      end
    end
  end

  task automatic drive(input logic we,
                       input logic [1:0] size,
                       input logic uns,
                       input logic [31:0] base,
                       input logic [31:0] off,
                       input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_base     = base;
    bus.req_offset   = off;
    bus.req_wdata    = wdata;
  endtask

  // called at posedge+1 with the unit idle
  task automatic issue(input logic we,
                       input logic [1:0] size,
                       input logic uns,
                       input logic [31:0] base,
                       input logic [31:0] off,
                       input logic [31:0] wdata,
                       input logic [31:0] exp_rd,
                       input logic [1:0] exp_err,
                       input int hold);
    bit done;
    if (hold > 0) bus.resp_ready = 1'b0;
    drive(we, size, uns, base, off, wdata);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sb.push_back({exp_err, exp_rd});
    chk("valid_at_n1", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("valid_at_n2", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rdata", bus.resp_rdata, exp_rd);
      chk("bp_err", 32'(bus.resp_err), 32'(exp_err));
      bus.req_valid = (i == 1);
      if (i == 1) drive(1'b1, 2'b10, 1'b0,
                        32'h104, 32'h0, 32'h0);
      @(posedge clk);
      #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (sb.size() == 0) && bus.req_ready;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout sb=%0d ready=%b",
               sb.size(), bus.req_ready);
      sb.delete();
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_base     = '0;
    bus.req_offset   = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1, 2'b10, 0, 32'h100, 32'h4, 32'hDEADBEEF, 32'h0, 2'b00, 0);
    issue(0, 2'b10, 0, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 2'b00, 0);
    issue(0, 2'b00, 0, 32'h100, 32'h7, 32'h0, 32'hFFFFFFDE, 2'b00, 0);
    issue(0, 2'b00, 1, 32'h100, 32'h7, 32'h0, 32'h000000DE, 2'b00, 0);
    issue(0, 2'b01, 0, 32'h100, 32'h4, 32'h0, 32'hFFFFBEEF, 2'b00, 0);
    issue(0, 2'b01, 1, 32'h100, 32'h6, 32'h0, 32'h0000DEAD, 2'b00, 0);
    issue(1, 2'b00, 0, 32'h100, 32'h5, 32'hAAAAAA55, 32'h0, 2'b00, 0);
    issue(0, 2'b10, 0, 32'h100, 32'h4, 32'h0, 32'hDEAD55EF, 2'b00, 0);
    issue(1, 2'b01, 0, 32'h106, 32'h0, 32'hBBBB1234, 32'h0, 2'b00, 0);
    issue(0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'h123455EF, 2'b00, 0);

    issue(0, 2'b10, 0, 32'h100, 32'h2, 32'h0, 32'h0, 2'b01, 0);
    issue(0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 32'h0, 2'b01, 0);
    issue(1, 2'b10, 0, 32'h0, 32'h0, 32'h11223344, 32'h0, 2'b00, 0);
    issue(1, 2'b10, 0, 32'h00040000, 32'h0, 32'hFFFFFFFF, 32'h0, 2'b10, 0);
    issue(1, 2'b01, 0, 32'h00040000, 32'h1, 32'hFFFFFFFF, 32'h0, 2'b01, 0);
    issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 32'h11223344, 2'b00, 0);

    issue(1, 2'b10, 0, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 32'h0, 2'b00, 0);
    issue(0, 2'b10, 0, 32'h4, 32'h0, 32'h0, 32'hCAFEF00D, 2'b00, 0);

    issue(0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'h123455EF, 2'b00, 5);
    issue(0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'h123455EF, 2'b00, 0);

    issue(1, 2'b10, 0, 32'h200, 32'h0, 32'hA5A5A5A5, 32'h0, 2'b00, 0);
    drive(1, 2'b10, 0, 32'h200, 32'h0, 32'h12345678);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 2'b10, 0, 32'h200, 32'h0, 32'h0, 32'hA5A5A5A5, 2'b00, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
